// File: rtl/bmp_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bmp_pkt_pkg
// Purpose  : Shared state encoding, header/trailer sizes and flag bit
//            positions for the BMP UDP packetizer (SEND_SUM exists only
//            when BMP_PKT_CHKSUM_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
package bmp_pkt_pkg;

  localparam int HDR_BYTES      = 4;
  localparam int SUM_BYTES      = 2;
  localparam int FLAG_FIRST_BIT = 0;
  localparam int FLAG_LAST_BIT  = 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_RDY,
    REQ,
    SEND_HDR,
    SEND_DATA,
`ifdef BMP_PKT_CHKSUM_EN
    SEND_SUM,
`endif
    GAP
  } pkt_state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_buf_ram.sv
`default_nettype none
// ============================================================================
// Module   : pkt_buf_ram
// Purpose  : Simple dual-port byte RAM holding one packet payload,
//            registered read port (1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module pkt_buf_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:DEPTH-1];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bmp_udp_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : bmp_udp_packetizer
// Purpose  : Slices a BMP byte stream into sequenced UDP payloads with a
//            4-byte header; BMP_PKT_CHKSUM_EN appends a 16-bit sum trailer.
// Revision : 1.0 - initial release
// ============================================================================
module bmp_udp_packetizer
  import bmp_pkt_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1024,
  parameter int IFG_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        udp_tx_ready,
  input  logic        app_tx_ack,
  output logic        app_tx_data_request,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_data_length,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] pkt_count
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
`ifdef BMP_PKT_CHKSUM_EN
  localparam logic [15:0] c_len_extra = 16'(HDR_BYTES + SUM_BYTES);
`else
  localparam logic [15:0] c_len_extra = 16'(HDR_BYTES);
`endif
  localparam logic [15:0] c_max      = 16'(MAX_PAYLOAD);
  localparam logic [15:0] c_hdr_last = 16'(HDR_BYTES - 1);
  localparam logic [31:0] c_ack_last = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] c_gap_last = (IFG_CYCLES > 0) ? 32'(IFG_CYCLES - 1) : 32'd0;

  pkt_state_t    r_state;
  pkt_state_t    w_next;
  logic [15:0]   r_seq;
  logic          r_first;
  logic          r_last;
  logic [15:0]   r_cnt;
  logic [15:0]   r_len;
  logic [15:0]   r_idx;
  logic [31:0]   r_timer;
  logic [31:0]   r_gap;
  logic [15:0]   r_pkt_count;
  logic          r_frame_done;
`ifdef BMP_PKT_CHKSUM_EN
  logic [15:0]   r_sum;
`endif

  logic          w_accept;
  logic [15:0]   w_cnt_inc;
  logic [15:0]   w_idx_inc;
  logic          w_fill_done;
  logic          w_data_done;
  logic          w_pkt_done;
  logic          w_gap_done;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    w_rd_data;
  logic [7:0]    w_tx_data;
  logic [7:0]    w_flags;

  assign in_ready            = (r_state == FILL);
  assign busy                = (r_state != IDLE);
  assign app_tx_data_request = (r_state == REQ);
  assign udp_data_length     = r_len;
  assign pkt_count           = r_pkt_count;
  assign frame_done          = r_frame_done;
  assign app_tx_data         = w_tx_data;

  assign w_accept    = in_valid & in_ready;
  assign w_cnt_inc   = r_cnt + 16'd1;
  assign w_idx_inc   = r_idx + 16'd1;
  assign w_fill_done = w_accept && ((w_cnt_inc == c_max) || in_last);
  assign w_data_done = (r_state == SEND_DATA) && (r_idx == r_cnt - 16'd1);
  assign w_gap_done  = (r_state == GAP) && (r_gap == c_gap_last);
`ifdef BMP_PKT_CHKSUM_EN
  assign w_pkt_done  = (r_state == SEND_SUM) && (r_idx == 16'd1);
`else
  assign w_pkt_done  = w_data_done;
`endif

  // Read one byte ahead: the last header cycle fetches byte 0, each data
  // cycle fetches the next byte, so the RAM latency never opens a gap.
  assign w_rd_en   = (r_state == SEND_HDR) || ((r_state == SEND_DATA) && (w_idx_inc < r_cnt));
  assign w_rd_addr = (r_state == SEND_HDR) ? '0 : w_idx_inc[AW-1:0];

  pkt_buf_ram #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_buf (
    .clk     (sys_clk),
    .i_we    (w_accept),
    .i_waddr (r_cnt[AW-1:0]),
    .i_wdata (in_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_tx_data = 8'h00;
    w_flags   = 8'h00;
    w_flags[FLAG_FIRST_BIT] = r_first;
    w_flags[FLAG_LAST_BIT]  = r_last;
    case (r_state)
      IDLE:     if (frame_start) w_next = FILL;
      FILL:     if (w_fill_done) w_next = WAIT_RDY;
      WAIT_RDY: if (udp_tx_ready) w_next = REQ;
      REQ: begin
        if (app_tx_ack) begin
          w_next = SEND_HDR;
        end else if (r_timer == c_ack_last) begin
          w_next = WAIT_RDY;
        end
      end
      SEND_HDR: begin
        case (r_idx[1:0])
          2'd0:    w_tx_data = r_seq[15:8];
          2'd1:    w_tx_data = r_seq[7:0];
          2'd2:    w_tx_data = w_flags;
          default: w_tx_data = 8'h00;
        endcase
        if (r_idx == c_hdr_last) w_next = SEND_DATA;
      end
      SEND_DATA: begin
        w_tx_data = w_rd_data;
`ifdef BMP_PKT_CHKSUM_EN
        if (w_data_done) w_next = SEND_SUM;
`else
        if (w_data_done) w_next = GAP;
`endif
      end
`ifdef BMP_PKT_CHKSUM_EN
      SEND_SUM: begin
        w_tx_data = r_idx[0] ? r_sum[7:0] : r_sum[15:8];
        if (w_pkt_done) w_next = GAP;
      end
`endif
      GAP:      if (w_gap_done) w_next = r_last ? IDLE : FILL;
      default:  w_next = IDLE;
    endcase
  end

  assign app_tx_data_valid = (r_state == SEND_HDR) || (r_state == SEND_DATA)
`ifdef BMP_PKT_CHKSUM_EN
                             || (r_state == SEND_SUM)
`endif
                             ;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_seq        <= 16'd0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_cnt        <= 16'd0;
      r_len        <= 16'd0;
      r_idx        <= 16'd0;
      r_timer      <= 32'd0;
      r_gap        <= 32'd0;
      r_pkt_count  <= 16'd0;
      r_frame_done <= 1'b0;
`ifdef BMP_PKT_CHKSUM_EN
      r_sum        <= 16'd0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_seq   <= 16'd0;
            r_first <= 1'b1;
            r_cnt   <= 16'd0;
          end
        end
        FILL: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
          end
          if (w_fill_done) begin
            r_len  <= c_len_extra + w_cnt_inc;
            r_last <= in_last;
          end
        end
        WAIT_RDY: r_timer <= 32'd0;
        REQ: begin
          r_timer <= r_timer + 32'd1;
          r_idx   <= 16'd0;
`ifdef BMP_PKT_CHKSUM_EN
          r_sum   <= 16'd0;
`endif
        end
        SEND_HDR:  r_idx <= (r_idx == c_hdr_last) ? 16'd0 : w_idx_inc;
        SEND_DATA: r_idx <= w_data_done ? 16'd0 : w_idx_inc;
`ifdef BMP_PKT_CHKSUM_EN
        SEND_SUM:  r_idx <= w_idx_inc;
`endif
        GAP: begin
          r_gap <= r_gap + 32'd1;
          if (w_gap_done) begin
            if (r_last) begin
              r_frame_done <= 1'b1;
            end else begin
              r_cnt <= 16'd0;
            end
          end
        end
        default: ;
      endcase
`ifdef BMP_PKT_CHKSUM_EN
      if ((r_state == SEND_HDR) || (r_state == SEND_DATA)) begin
        r_sum <= r_sum + {8'h00, w_tx_data};
      end
`endif
      if (w_pkt_done) begin
        r_seq       <= r_seq + 16'd1;
        r_first     <= 1'b0;
        r_pkt_count <= r_pkt_count + 16'd1;
        r_gap       <= 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bmp_udp_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmp_udp_packetizer
// Purpose  : Directed self-checking bench for bmp_udp_packetizer; the
//            checksum scenario is built when BMP_PKT_CHKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bmp_udp_packetizer;

`ifdef BMP_PKT_CHKSUM_EN
  localparam int SUMB = 2;
`else
  localparam int SUMB = 0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        frame_start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        udp_tx_ready;
  logic        app_tx_ack;
  logic        app_tx_data_request;
  logic        app_tx_data_valid;
  logic [7:0]  app_tx_data;
  logic [15:0] udp_data_length;
  logic        busy;
  logic        frame_done;
  logic [15:0] pkt_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int fd_count     = 0;
  logic [7:0] rx_buf [0:2047];

  always #10 sys_clk = ~sys_clk;

  bmp_udp_packetizer dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .frame_start         (frame_start),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_last             (in_last),
    .in_ready            (in_ready),
    .udp_tx_ready        (udp_tx_ready),
    .app_tx_ack          (app_tx_ack),
    .app_tx_data_request (app_tx_data_request),
    .app_tx_data_valid   (app_tx_data_valid),
    .app_tx_data         (app_tx_data),
    .udp_data_length     (udp_data_length),
    .busy                (busy),
    .frame_done          (frame_done),
    .pkt_count           (pkt_count)
  );

  always @(negedge sys_clk) begin
    if (!sys_rst && frame_done === 1'b1) fd_count++;
  end

  function automatic int first_mismatch(input int len, input int seq, input int flags,
                                        input int seed, input int step, input int off);
    logic [7:0]  exp;
    logic [15:0] sum;
    int n;
    sum = 16'd0;
    n   = len - 4 - SUMB;
    for (int k = 0; k < len && k < 2048; k++) begin
      if (k == 0)          exp = 8'(seq >> 8);
      else if (k == 1)     exp = 8'(seq);
      else if (k == 2)     exp = 8'(flags);
      else if (k == 3)     exp = 8'h00;
      else if (k < 4 + n)  exp = 8'(seed + (off + k - 4) * step);
      else if (k == 4 + n) exp = sum[15:8];
      else                 exp = sum[7:0];
      if (k < 4 + n) sum = sum + {8'h00, exp};
      if (rx_buf[k] !== exp) return k;
    end
    return -1;
  endfunction

  task automatic start_frame();
    @(negedge sys_clk);
    frame_start = 1'b1;
    @(negedge sys_clk);
    frame_start = 1'b0;
  endtask

  task automatic feed(input int n, input int seed, input int step);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 60000) begin
      @(negedge sys_clk);
      in_valid = 1'b1;
      in_data  = 8'(seed + i * step);
      in_last  = (i == n - 1);
      if (in_ready === 1'b1) i++;
      guard++;
    end
    @(negedge sys_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests_run++;
    if (i !== n) begin
      tests_failed++;
      $display("FAIL feed_accept: accepted %0d bytes, required %0d", i, n);
    end
  endtask

  task automatic rx_packet(input int budget, output int len);
    int w = 0;
    int bad = 0;
    len = -1;
    app_tx_ack = 1'b0;
    @(negedge sys_clk);
    while (app_tx_data_request !== 1'b1 && w < budget) begin
      @(negedge sys_clk);
      w++;
    end
    if (app_tx_data_request !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL rx_request: request=%b after %0d cycles, required 1", app_tx_data_request, w);
      return;
    end
    app_tx_ack = 1'b1;
    @(negedge sys_clk);
    app_tx_ack = 1'b0;
    len = int'(udp_data_length);
    for (int k = 0; k < len && k < 2048; k++) begin
      if (app_tx_data_valid !== 1'b1 || udp_data_length !== 16'(len)) bad++;
      rx_buf[k] = app_tx_data;
      @(negedge sys_clk);
    end
    tests_run++;
    if (bad !== 0 || app_tx_data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_valid_window: %0d gap/len-change cycles, valid after=%b, required 0/0",
               bad, app_tx_data_valid);
    end
  endtask

  task automatic wait_idle(input int budget);
    int w = 0;
    while (busy !== 1'b0 && w < budget) begin
      @(negedge sys_clk);
      w++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, w);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; frame_start = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    udp_tx_ready = 1'b0; app_tx_ack = 1'b0;
    repeat (3) @(negedge sys_clk);
    tests_run++;
    if ({in_ready, app_tx_data_request, app_tx_data_valid, busy, frame_done} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {rdy,req,vld,busy,fd}=%b required 00000",
               {in_ready, app_tx_data_request, app_tx_data_valid, busy, frame_done});
    end
    tests_run++;
    if (app_tx_data !== 8'h00 || udp_data_length !== 16'd0 || pkt_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_data: data=%h len=%0d pkt_count=%0d required 00/0/0",
               app_tx_data, udp_data_length, pkt_count);
    end
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b in_ready=%b required 0/0", busy, in_ready);
    end
  endtask

  task automatic test_multi_packet();
    int lens [3];
    int mm   [3];
    int flg  [3];
    int fd0;
    flg = '{1, 0, 2};
    fd0 = fd_count;
    udp_tx_ready = 1'b1;
    start_frame();
    fork
      feed(2500, 5, 3);
      begin
        for (int p = 0; p < 3; p++) begin
          rx_packet(20000, lens[p]);
          mm[p] = first_mismatch(lens[p], p, flg[p], 5, 3, p * 1024);
          if (p == 0) begin
            // a stray frame_start mid-frame must not restart the sequence
            @(negedge sys_clk);
            frame_start = 1'b1;
            @(negedge sys_clk);
            frame_start = 1'b0;
          end
        end
      end
    join
    for (int p = 0; p < 3; p++) begin
      tests_run++;
      if (lens[p] !== ((p == 2) ? 456 : 1028) + SUMB) begin
        tests_failed++;
        $display("FAIL multi_len[%0d]: got %0d required %0d", p, lens[p], ((p == 2) ? 456 : 1028) + SUMB);
      end
      tests_run++;
      if (mm[p] !== -1) begin
        tests_failed++;
        $display("FAIL multi_bytes[%0d]: first bad byte index %0d value %h, required none", p, mm[p],
                 rx_buf[(mm[p] < 0) ? 0 : mm[p]]);
      end
    end
    wait_idle(200);
    repeat (5) @(negedge sys_clk);
    tests_run++;
    if (fd_count - fd0 !== 1 || pkt_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL multi_done: frame_done pulses=%0d pkt_count=%0d required 1/3", fd_count - fd0, pkt_count);
    end
  endtask

  task automatic test_exact_max();
    int len;
    int mm;
    int fd0;
    int req_seen = 0;
    fd0 = fd_count;
    udp_tx_ready = 1'b1;
    start_frame();
    fork
      feed(1024, 9, 1);
      rx_packet(20000, len);
    join
    mm = first_mismatch(len, 0, 3, 9, 1, 0);
    tests_run++;
    if (len !== 1028 + SUMB || mm !== -1) begin
      tests_failed++;
      $display("FAIL exact_max_pkt: len=%0d bad_idx=%0d required %0d/-1", len, mm, 1028 + SUMB);
    end
    repeat (300) begin
      @(negedge sys_clk);
      if (app_tx_data_request === 1'b1) req_seen++;
    end
    tests_run++;
    if (req_seen !== 0 || fd_count - fd0 !== 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL exact_max_tail: extra req cycles=%0d frame_done=%0d busy=%b required 0/1/0",
               req_seen, fd_count - fd0, busy);
    end
  endtask

  task automatic test_ack_timeout();
    int len;
    int mm;
    int w = 0;
    int cnt = 0;
    udp_tx_ready = 1'b1;
    start_frame();
    feed(1, 8'hA5, 0);
    while (app_tx_data_request !== 1'b1 && w < 100) begin
      @(negedge sys_clk);
      w++;
    end
    while (app_tx_data_request === 1'b1 && cnt < 5000) begin
      cnt++;
      @(negedge sys_clk);
    end
    tests_run++;
    if (cnt !== 4096) begin
      tests_failed++;
      $display("FAIL ack_timeout_window: request high %0d cycles, required 4096", cnt);
    end
    rx_packet(100, len);
    mm = first_mismatch(len, 0, 3, 8'hA5, 0, 0);
    tests_run++;
    if (len !== 5 + SUMB || mm !== -1) begin
      tests_failed++;
      $display("FAIL ack_retry_pkt: len=%0d bad_idx=%0d required %0d/-1", len, mm, 5 + SUMB);
    end
    wait_idle(100);
  endtask

  task automatic test_not_ready();
    int len;
    int mm;
    int bad = 0;
    udp_tx_ready = 1'b0;
    start_frame();
    feed(5, 8'h40, 1);
    repeat (100) begin
      @(negedge sys_clk);
      if (app_tx_data_request !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL not_ready_hold: %0d cycles with request/in_ready high, required 0", bad);
    end
    udp_tx_ready = 1'b1;
    rx_packet(100, len);
    mm = first_mismatch(len, 0, 3, 8'h40, 1, 0);
    tests_run++;
    if (len !== 9 + SUMB || mm !== -1) begin
      tests_failed++;
      $display("FAIL not_ready_pkt: len=%0d bad_idx=%0d required %0d/-1", len, mm, 9 + SUMB);
    end
    wait_idle(100);
  endtask

  task automatic test_reset_mid_send();
    int len;
    int mm;
    int w = 0;
    udp_tx_ready = 1'b1;
    start_frame();
    feed(50, 8'h11, 2);
    while (app_tx_data_request !== 1'b1 && w < 100) begin
      @(negedge sys_clk);
      w++;
    end
    app_tx_ack = 1'b1;
    @(negedge sys_clk);
    app_tx_ack = 1'b0;
    repeat (9) @(negedge sys_clk);
    tests_run++;
    if (app_tx_data_valid !== 1'b1 || pkt_count !== 16'd6) begin
      tests_failed++;
      $display("FAIL mid_send_pre: valid=%b pkt_count=%0d required 1/6", app_tx_data_valid, pkt_count);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    tests_run++;
    if (app_tx_data_valid !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_send_reset: valid=%b busy=%b pkt_count=%0d required 0/0/0",
               app_tx_data_valid, busy, pkt_count);
    end
    sys_rst = 1'b0;
    start_frame();
    feed(3, 8'h21, 1);
    rx_packet(100, len);
    mm = first_mismatch(len, 0, 3, 8'h21, 1, 0);
    tests_run++;
    if (len !== 7 + SUMB || mm !== -1) begin
      tests_failed++;
      $display("FAIL post_reset_pkt: len=%0d bad_idx=%0d required %0d/-1", len, mm, 7 + SUMB);
    end
    wait_idle(100);
  endtask

`ifdef BMP_PKT_CHKSUM_EN
  task automatic test_checksum();
    int len;
    udp_tx_ready = 1'b1;
    start_frame();
    feed(3, 1, 1);
    rx_packet(100, len);
    tests_run++;
    if (len !== 9 || rx_buf[7] !== 8'h00 || rx_buf[8] !== 8'h09) begin
      tests_failed++;
      $display("FAIL checksum_trailer: len=%0d trailer=%h%h required 9/0009", len, rx_buf[7], rx_buf[8]);
    end
    wait_idle(100);
  endtask
`endif

  initial begin
    test_reset();
    test_multi_packet();
    test_exact_max();
    test_ack_timeout();
    test_not_ready();
    test_reset_mid_send();
`ifdef BMP_PKT_CHKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
